// File: rtl/alarm_snooze_ctrl.sv
// Alarm sequencing controller: detects the alarm-minute edge, then runs
// ringing, snooze, auto-timeout and dismissal toward the sound/LCD path.
module alarm_snooze_ctrl #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       clock,
  input  logic       reset_delay,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       alarm_enable,
  input  logic       snooze_button,
  input  logic       stop_button,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  output logic       alarm_sound,
  output logic       snooze_active,
  output logic [2:0] snooze_count,
  output logic [1:0] ctrl_state
);

  localparam int unsigned RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int unsigned SNZ_W  = 4;
  localparam int unsigned CNT_W  = 3;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0]  SNZ_MAX   = CNT_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RINGING   = 2'b01,
    ST_SNOOZE    = 2'b10,
    ST_DISMISSED = 2'b11
  } state_e;

  state_e             state_q;
  logic               match_q;
  logic               snz_q;
  logic               stp_q;
  logic [RING_W-1:0]  ring_cnt_q;
  logic [SNZ_W-1:0]   snz_cnt_q;
  logic [CNT_W-1:0]   snz_used_q;

  logic match;
  logic trigger;
  logic snz_p;
  logic stp_p;

  assign match = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                 (current_time_ls_hr  == alarm_time_ls_hr)  &&
                 (current_time_ms_min == alarm_time_ms_min) &&
                 (current_time_ls_min == alarm_time_ls_min);

  assign trigger = match & ~match_q & alarm_enable;
  assign snz_p   = snooze_button & ~snz_q;
  assign stp_p   = stop_button & ~stp_q;

  // Outputs decode straight from the state register, so reset silences them at once.
  assign alarm_sound   = (state_q == ST_RINGING);
  assign snooze_active = (state_q == ST_SNOOZE);
  assign snooze_count  = snz_used_q;
  assign ctrl_state    = state_q;

  always_ff @(posedge clock or posedge reset_delay) begin
    if (reset_delay) begin
      state_q    <= ST_IDLE;
      match_q    <= 1'b0;
      snz_q      <= 1'b0;
      stp_q      <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      snz_used_q <= '0;
    end else begin
      match_q <= match;
      snz_q   <= snooze_button;
      stp_q   <= stop_button;

      // Disarming overrides every other event in any active state.
      if ((state_q != ST_IDLE) && !alarm_enable) begin
        state_q    <= ST_IDLE;
        ring_cnt_q <= '0;
        snz_cnt_q  <= '0;
        snz_used_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trigger) begin
              state_q    <= ST_RINGING;
              ring_cnt_q <= '0;
              snz_used_q <= '0;
            end
          end

          ST_RINGING: begin
            if (stp_p) begin
              state_q    <= ST_DISMISSED;
              snz_used_q <= '0;
            end else if (one_second && (ring_cnt_q == RING_LAST)) begin
              state_q    <= ST_DISMISSED;
              ring_cnt_q <= '0;
              snz_used_q <= '0;
            end else if (snz_p && (snz_used_q < SNZ_MAX)) begin
              state_q    <= ST_SNOOZE;
              snz_used_q <= snz_used_q + CNT_W'(1);
              snz_cnt_q  <= SNZ_LOAD;
            end else if (one_second) begin
              ring_cnt_q <= ring_cnt_q + RING_W'(1);
            end
          end

          ST_SNOOZE: begin
            if (stp_p) begin
              state_q    <= ST_DISMISSED;
              snz_cnt_q  <= '0;
              snz_used_q <= '0;
            end else if (one_minute) begin
              if (snz_cnt_q <= SNZ_W'(1)) begin
                state_q    <= ST_RINGING;
                ring_cnt_q <= '0;
                snz_cnt_q  <= '0;
              end else begin
                snz_cnt_q <= snz_cnt_q - SNZ_W'(1);
              end
            end
          end

          ST_DISMISSED: begin
            // Holding here while the alarm minute persists blocks a re-trigger.
            snz_used_q <= '0;
            if (!match) begin
              state_q <= ST_IDLE;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/alarm_snooze_ctrl.md
Name: alarm_snooze_ctrl

Overview:
Alarm sequencing controller for the alarm clock datapath. It compares the running time from the minute counter against the stored alarm time, and sequences ringing, snooze, auto-timeout and dismissal. It drives the alarm sound and snooze status toward the LCD/sound path. It sits between the counter/alarm register outputs and the display driver, and is clocked by the system clock with one_second/one_minute strobes from the timing generator.

Parameters:
SNOOZE_MIN, 5, snooze duration in minutes (1..15)
MAX_SNOOZE, 3, maximum snoozes per alarm event (1..7)
RING_SEC, 60, ring duration in seconds before auto-dismiss (2..127)

Ports:
clock  in  1  system clock
reset_delay  in  1  reset, asynchronous, active-high
one_second  in  1  single-cycle strobe, once per second
one_minute  in  1  single-cycle strobe, once per minute
alarm_enable  in  1  level; alarm armed when high
snooze_button  in  1  level button, rising-edge detected internally
stop_button  in  1  level button, rising-edge detected internally
current_time_ms_hr/ls_hr/ms_min/ls_min  in  4 each  BCD current time
alarm_time_ms_hr/ls_hr/ms_min/ls_min  in  4 each  BCD alarm time
alarm_sound  out  1  high while ringing
snooze_active  out  1  high while in SNOOZE
snooze_count  out  3  snoozes used in current event
ctrl_state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE, 11 DISMISSED

Behaviour:
- Reset (async, reset_delay=1): state IDLE; alarm_sound=0, snooze_active=0, snooze_count=0, ctrl_state=00; match_q=0, button edge registers=0, ring/snooze timers=0. Reset mid-RINGING/SNOOZE aborts immediately; sound drops asynchronously.
- match = all four current digits equal the corresponding alarm digits (combinational). match_q = match registered each clock.
- trigger = match & ~match_q & alarm_enable.
- snz_p = snooze_button & ~snz_q. stp_p = stop_button & ~stp_q. The q registers sample the buttons every clock.
- Outputs are decoded from registered state. alarm_sound = (state==RINGING). snooze_active = (state==SNOOZE).
- Priority in every non-IDLE state: alarm_enable=0 > stp_p > timer expiry > snz_p.
- IDLE:
  - trigger -> RINGING; ring_cnt=0; snooze_count=0.
  - Sound asserts one clock after the first clock with match=1.
- RINGING:
  - ring_cnt increments on one_second.
  - one_second with ring_cnt==RING_SEC-1 -> DISMISSED (auto-timeout).
  - stp_p -> DISMISSED.
  - snz_p with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count+1; snz_cnt=SNOOZE_MIN.
  - snz_p with snooze_count==MAX_SNOOZE is ignored; ringing continues and ring_cnt is not reset.
- SNOOZE:
  - snz_cnt decrements on one_minute.
  - one_minute with snz_cnt==1 -> RINGING; ring_cnt=0.
  - stp_p -> DISMISSED.
  - snz_p is ignored.
- DISMISSED:
  - snooze_count cleared.
  - match==0 -> IDLE. Remaining DISMISSED while match==1 prevents re-triggering within the alarm minute.
- Any state except IDLE: alarm_enable=0 -> IDLE, clearing snooze_count and timers. Takes priority over all other events in that cycle.
- Simultaneous stp_p and snz_p: stop wins (DISMISSED).
- Simultaneous timeout and snz_p: timeout wins (DISMISSED).
- Time load changing current time onto the alarm time produces a match rising edge and triggers normally.
- Alarm time changed while ringing does not stop ringing.
- Counter widths: ring_cnt $clog2(RING_SEC) bits. snz_cnt 4 bits. No wrap; counters saturate by construction.

Test Plan:
- Alarm 07:30, enable=1, current steps 07:29->07:30 -> alarm_sound=1 one clock after match, ctrl_state=01; after 60 one_second strobes -> ctrl_state=11, sound=0; current 07:31 -> IDLE.
- Ringing, snooze pulse -> ctrl_state=10, snooze_count=1, sound=0; after 5 one_minute strobes -> RINGING, sound=1.
- Snooze three times, then fourth snooze pulse while ringing -> stays RINGING, snooze_count=3; stop pulse -> DISMISSED, snooze_count=0.
- stop_button and snooze_button rise in the same clock while ringing -> DISMISSED, snooze_count unchanged-then-cleared, never enters SNOOZE.
- Hold stop_button high for 10 clocks, then snooze pulse -> single stop event only; a level held high produces no repeated actions.
- Assert reset_delay mid-RINGING -> alarm_sound=0 asynchronously, all outputs 0. Separately, drop alarm_enable during SNOOZE -> IDLE next clock, snooze_count=0, no later ring.
